// File: rtl/softmax_out_writer_pkg.sv
// softmax_out_writer_pkg: shared widths, FSM states and lane-sum helper for the softmax writeback stage
package softmax_out_writer_pkg;
    localparam int DATAWIDTH = 16;
    localparam int NUM = 4;
    localparam int ADDRSIZE = 8;
    localparam int WORDW = DATAWIDTH * NUM;
    localparam int CSUM_W = DATAWIDTH + 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN = 2'd1,
        FINISH = 2'd2
    } state_t;
    function automatic logic [CSUM_W-1:0] lane_sum(input logic [WORDW-1:0] w);
        lane_sum = '0;
        for (int k = 0; k < NUM; k++) lane_sum += CSUM_W'(w[k*DATAWIDTH +: DATAWIDTH]);
    endfunction
endpackage

// File: rtl/softmax_wb_fifo.sv
// softmax_wb_fifo: synchronous beat FIFO; push and pop together while full is legal
module softmax_wb_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rd_ptr];
    // storage and pointers; reset clears storage so the head reads zero
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/softmax_out_writer.sv
// softmax_out_writer: packs 4-lane softmax beats and writes them to sequential output memory; SOFTMAX_WB_CHECKSUM_EN adds a lane-sum checksum
module softmax_out_writer
    import softmax_out_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDRSIZE-1:0]  out_base,
    input  logic [ADDRSIZE-1:0]  num_words,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in0,
    input  logic [DATAWIDTH-1:0] in1,
    input  logic [DATAWIDTH-1:0] in2,
    input  logic [DATAWIDTH-1:0] in3,
    output logic                 wr_en,
    output logic [ADDRSIZE-1:0]  wr_addr,
    output logic [WORDW-1:0]     wr_data,
    input  logic                 wr_ready,
    output logic                 busy,
    output logic                 finish,
    output logic                 overflow
`ifdef SOFTMAX_WB_CHECKSUM_EN
    , output logic [CSUM_W-1:0]  checksum
`endif
);
    state_t state, state_nx;
    logic [ADDRSIZE-1:0] base, nw, rx_cnt, wcnt;
    logic start_ok, accept, push, pop, full, empty;
    logic [WORDW-1:0] head;

    softmax_wb_fifo #(.W(WORDW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din({in3, in2, in1, in0}),
        .full(full),
        .empty(empty),
        .head(head)
    );

    // next state, push/pop decisions and write-port outputs
    always_comb begin
        state_nx = state;
        start_ok = state == IDLE && start;
        accept = state == RUN && in_valid && rx_cnt != nw;
        pop = !empty && wr_ready;
        push = accept && (!full || pop);
        wr_en = !empty;
        wr_data = head;
        wr_addr = base + wcnt;
        busy = state == RUN;
        finish = state == FINISH;
        state_nx = start_ok ? (num_words == '0 ? FINISH : RUN)
                 : (state == RUN && rx_cnt == nw && empty) ? FINISH
                 : state == FINISH ? IDLE : state;
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // run parameters, beat/word counters and sticky drop flag
    always_ff @(posedge clk) begin
        if (reset) begin
            base <= '0;
            nw <= '0;
            rx_cnt <= '0;
            wcnt <= '0;
            overflow <= 1'b0;
        end else if (start_ok) begin
            base <= out_base;
            nw <= num_words;
            rx_cnt <= '0;
            wcnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) rx_cnt <= rx_cnt + ADDRSIZE'(1);
            if (accept && !push) overflow <= 1'b1;
            if (pop) wcnt <= wcnt + ADDRSIZE'(1);
        end
    end

`ifdef SOFTMAX_WB_CHECKSUM_EN
    // running sum of all lanes of every word handed to memory
    always_ff @(posedge clk) begin
        if (reset || start_ok) checksum <= '0;
        else if (pop) checksum <= checksum + lane_sum(head);
    end
`endif
endmodule

// File: tb/tb_softmax_out_writer.sv
// tb_softmax_out_writer: table vectors, directed corner sequences and random runs against a queue-based model
module tb_softmax_out_writer;
    import softmax_out_writer_pkg::*;
    localparam int DEPTH = 4;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, wr_ready = 1'b0;
    logic [7:0] out_base = '0, num_words = '0;
    logic [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic wr_en, busy, finish, overflow;
    logic [7:0] wr_addr;
    logic [63:0] wr_data;
`ifdef SOFTMAX_WB_CHECKSUM_EN
    logic [23:0] checksum;
`endif

    always #5 clk = ~clk;

    softmax_out_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .out_base(out_base),
        .num_words(num_words),
        .in_valid(in_valid),
        .in0(in0),
        .in1(in1),
        .in2(in2),
        .in3(in3),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .busy(busy),
        .finish(finish),
        .overflow(overflow)
`ifdef SOFTMAX_WB_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    int n_chk = 0, n_fail = 0;
    int m_st = 0;
    logic [7:0] m_base = '0, m_n = '0, m_rx = '0, m_wc = '0;
    bit m_ovf = 1'b0;
    logic [23:0] m_sum = '0;
    logic [63:0] m_q[$];
    logic [7:0] log_addr[$];
    logic [63:0] log_data[$];
    bit fin_seen = 1'b0;

    typedef struct {
        bit st;
        logic [7:0] base;
        logic [7:0] n;
        bit iv;
        logic [63:0] lanes;
        bit rdy;
        bit e_en;
        logic [7:0] e_addr;
        logic [63:0] e_data;
        bit e_busy;
        bit e_fin;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] lsum(input logic [63:0] w);
        return 24'(w[15:0]) + 24'(w[31:16]) + 24'(w[47:32]) + 24'(w[63:48]);
    endfunction

    task automatic set_beat(input logic [63:0] w);
        {in3, in2, in1, in0} = w;
    endtask

    task automatic tick();
        bit p, a;
        int sz;
        @(posedge clk);
        if (reset) begin
            m_st = 0; m_base = '0; m_n = '0; m_rx = '0; m_wc = '0; m_ovf = 1'b0; m_sum = '0;
            m_q.delete();
        end else begin
            sz = m_q.size();
            p = sz > 0 && wr_ready;
            a = m_st == 1 && in_valid && m_rx != m_n;
            if (m_st == 0) begin
                if (start) begin
                    m_base = out_base; m_n = num_words; m_rx = '0; m_wc = '0; m_ovf = 1'b0; m_sum = '0;
                    m_st = (num_words == 0) ? 2 : 1;
                end
            end else if (m_st == 1) begin
                if (m_rx == m_n && sz == 0) m_st = 2;
            end else m_st = 0;
            if (p) begin
                m_sum += lsum(m_q[0]);
                void'(m_q.pop_front());
                m_wc++;
            end
            if (a) begin
                m_rx++;
                if (sz < DEPTH || p) m_q.push_back({in3, in2, in1, in0});
                else m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic cyc();
        logic [7:0] ea;
        @(negedge clk);
        ea = m_base + m_wc;
        chk("wr_en", wr_en, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("wr_addr", wr_addr, ea);
            chk("wr_data", wr_data, m_q[0]);
        end
        chk("busy", busy, m_st == 1);
        chk("finish", finish, m_st == 2);
        chk("overflow", overflow, m_ovf);
`ifdef SOFTMAX_WB_CHECKSUM_EN
        chk("checksum", checksum, m_sum);
`endif
        if (wr_en && wr_ready) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (finish) fin_seen = 1'b1;
        tick();
    endtask

    task automatic run_until_finish(input int maxc);
        int c = 0;
        while (!fin_seen && c < maxc) begin
            cyc();
            c++;
        end
        chk("finish_within_budget", fin_seen, 1'b1);
    endtask

    task automatic begin_run(input logic [7:0] b, input logic [7:0] n, input bit rdy);
        log_addr.delete();
        log_data.delete();
        fin_seen = 1'b0;
        start = 1'b1; out_base = b; num_words = n; wr_ready = rdy; in_valid = 1'b0;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h10, 8'd4, 1'b0, 64'h0, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h10, 8'd4, 1'b1, 64'h0004_0003_0002_0001, 1'b1, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h10, 8'd4, 1'b1, 64'h0008_0007_0006_0005, 1'b1, 1'b1, 8'h10, 64'h0004_0003_0002_0001, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h10, 8'd4, 1'b1, 64'h000c_000b_000a_0009, 1'b1, 1'b1, 8'h11, 64'h0008_0007_0006_0005, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h10, 8'd4, 1'b1, 64'h0010_000f_000e_000d, 1'b1, 1'b1, 8'h12, 64'h000c_000b_000a_0009, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'h10, 8'd4, 1'b0, 64'h0, 1'b1, 1'b1, 8'h13, 64'h0010_000f_000e_000d, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 8'h10, 8'd4, 1'b0, 64'h0, 1'b1, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h10, 8'd4, 1'b0, 64'h0, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 8'h10, 8'd4, 1'b0, 64'h0, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0};

        @(posedge clk);
        #1;
        cyc();
        @(negedge clk);
        chk("reset_wr_addr", wr_addr, 8'h00);
        chk("reset_wr_data", wr_data, 64'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            start = tbl[i].st; out_base = tbl[i].base; num_words = tbl[i].n;
            in_valid = tbl[i].iv; set_beat(tbl[i].lanes); wr_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].e_en);
            if (tbl[i].e_en) begin
                chk($sformatf("tbl%0d_wr_addr", i), wr_addr, tbl[i].e_addr);
                chk($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].e_data);
            end
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_finish", i), finish, tbl[i].e_fin);
            chk($sformatf("tbl%0d_overflow", i), overflow, 1'b0);
`ifdef SOFTMAX_WB_CHECKSUM_EN
            if (i == 7) chk("tbl_checksum", checksum, 24'd136);
`endif
            tick();
        end
        start = 1'b0; in_valid = 1'b0;

        begin_run(8'h20, 8'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            set_beat({4{16'(16'h100 + k)}});
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        wr_ready = 1'b1;
        run_until_finish(20);
        chk("stall_overflow", overflow, 1'b0);
        chk("stall_writes", log_addr.size(), 3);
        for (int k = 0; k < 3 && k < log_addr.size(); k++) begin
            chk($sformatf("stall_addr%0d", k), log_addr[k], 8'h20 + 8'(k));
            chk($sformatf("stall_data%0d", k), log_data[k], {4{16'(16'h100 + k)}});
        end

        begin_run(8'h30, 8'd6, 1'b0);
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            set_beat({4{16'(16'h200 + k)}});
            cyc();
        end
        in_valid = 1'b0;
        wr_ready = 1'b1;
        run_until_finish(30);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_writes", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            chk("ovf_last_addr", log_addr[3], 8'h33);
            chk("ovf_last_data", log_data[3], {4{16'h203}});
        end

        begin_run(8'h50, 8'd0, 1'b1);
        cyc();
        chk("zero_finish_next", fin_seen, 1'b1);
        chk("zero_no_writes", log_addr.size(), 0);
        chk("zero_clears_ovf", overflow, 1'b0);

        begin_run(8'hFE, 8'd3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            set_beat({4{16'(16'h300 + k)}});
            cyc();
        end
        in_valid = 1'b0;
        run_until_finish(20);
        chk("wrap_writes", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("wrap_addr0", log_addr[0], 8'hFE);
            chk("wrap_addr1", log_addr[1], 8'hFF);
            chk("wrap_addr2", log_addr[2], 8'h00);
        end

        begin_run(8'h60, 8'd5, 1'b0);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            set_beat({4{16'(16'h400 + k)}});
            cyc();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        begin_run(8'h40, 8'd1, 1'b1);
        in_valid = 1'b1;
        set_beat(64'h0004_0003_0002_0001);
        cyc();
        in_valid = 1'b0;
        run_until_finish(20);
        chk("rst_new_writes", log_addr.size(), 1);
        if (log_addr.size() == 1) chk("rst_new_addr", log_addr[0], 8'h40);
`ifdef SOFTMAX_WB_CHECKSUM_EN
        chk("rst_new_checksum", checksum, 24'd10);
`endif

        for (int r = 0; r < 10; r++) begin
            begin_run(8'($urandom), 8'($urandom_range(1, 12)), 1'b1);
            for (int c = 0; c < 300 && !fin_seen; c++) begin
                in_valid = $urandom_range(0, 1) == 1;
                set_beat({$urandom, $urandom});
                wr_ready = $urandom_range(0, 9) < 6;
                start = $urandom_range(0, 7) == 0;
                out_base = 8'($urandom);
                num_words = 8'($urandom_range(0, 12));
                cyc();
            end
            start = 1'b0;
            in_valid = 1'b0;
            chk($sformatf("rand%0d_finished", r), fin_seen, 1'b1);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
